// File: rtl/fp_arb_pkg.sv
// Shared types and defaults for the floating-point unit arbiter.
package fp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr, wrapping to 0.
module rr_priority_picker #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx,
    output logic                       winner_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int cand;

    // Scan farthest-first so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        winner_idx   = '0;
        winner_valid = 1'b0;
        cand         = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req[IDX_W'(cand)]) begin
                winner_idx   = IDX_W'(cand);
                winner_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin sharing of one floating-point unit among NUM_REQ requesters,
// one transaction at a time, with a sticky timeout flag for a hung unit.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         result,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [DATA_WIDTH-1:0]         unit_operand_a,
    output logic [DATA_WIDTH-1:0]         unit_operand_b,
    output logic                          unit_start,
    input  logic                          unit_result_ready,
    input  logic [DATA_WIDTH-1:0]         unit_result,
    output arb_state_t                    state_dbg
);

    // Handshake: req is a level held by the requester until its one-cycle done
    // pulse; unit_start is a one-cycle request to the unit, unit_result_ready a
    // one-cycle valid for unit_result, honoured only in WAIT.

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [CNT_W-1:0] wait_cnt;
    logic [IDX_W-1:0] winner_idx;
    logic             winner_valid;

    logic [DATA_WIDTH-1:0] opa_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] opb_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            opa_arr[i] = req_operand_a[i*DATA_WIDTH +: DATA_WIDTH];
            opb_arr[i] = req_operand_b[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_priority_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .winner_idx  (winner_idx),
        .winner_valid(winner_valid)
    );

    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant_idx      <= '0;
            wait_cnt       <= '0;
            grant          <= '0;
            done           <= '0;
            result         <= '0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
            unit_operand_a <= '0;
            unit_operand_b <= '0;
            unit_start     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (winner_valid) begin
                        grant_idx      <= winner_idx;
                        grant          <= NUM_REQ'(1) << winner_idx;
                        unit_operand_a <= opa_arr[winner_idx];
                        unit_operand_b <= opb_arr[winner_idx];
                        busy           <= 1'b1;
                        // Raised here so the pulse is visible during the ISSUE cycle.
                        unit_start     <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    unit_start <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (unit_result_ready) begin
                        result <= unit_result;
                        done   <= grant;
                        state  <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        result      <= '0;
                        timeout_err <= 1'b1;
                        done        <= grant;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    rr_ptr         <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
                    grant          <= '0;
                    done           <= '0;
                    busy           <= 1'b0;
                    unit_operand_a <= '0;
                    unit_operand_b <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed and randomized checks of fp_unit_arbiter against a transaction-level model.
module tb_fp_unit_arbiter;
    import fp_arb_pkg::*;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*DW-1:0]  req_operand_a, req_operand_b;
    logic [NR-1:0]     grant, done;
    logic [DW-1:0]     result, unit_operand_a, unit_operand_b, unit_result;
    logic              busy, timeout_err, unit_start, unit_result_ready;
    arb_state_t        state_dbg;

    logic [DW-1:0] op_a [NR];
    logic [DW-1:0] op_b [NR];

    // Unit model controls
    int          unit_latency = 4;
    bit          unit_hang = 1'b0;
    bit          use_fixed = 1'b0;
    logic [DW-1:0] fixed_val = '0;
    logic        model_ready = 1'b0;
    logic        force_ready = 1'b0;
    logic [DW-1:0] unit_result_val = '0;
    logic [DW-1:0] cap_a = '0, cap_b = '0;
    int          model_cnt = 0;

    // Reference model state
    int ref_ptr = 0;
    bit exp_terr = 1'b0;

    int n_assert = 0;
    int n_fail = 0;

    fp_unit_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clock            (clock),
        .reset            (reset),
        .req              (req),
        .req_operand_a    (req_operand_a),
        .req_operand_b    (req_operand_b),
        .grant            (grant),
        .done             (done),
        .result           (result),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .unit_operand_a   (unit_operand_a),
        .unit_operand_b   (unit_operand_b),
        .unit_start       (unit_start),
        .unit_result_ready(unit_result_ready),
        .unit_result      (unit_result),
        .state_dbg        (state_dbg)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_operand_a[i*DW +: DW] = op_a[i];
            req_operand_b[i*DW +: DW] = op_b[i];
        end
    end

    assign unit_result_ready = model_ready | force_ready;
    assign unit_result = unit_result_val;

    // Shared-unit model: ready pulses unit_latency cycles after the start cycle.
    always @(posedge clock) begin
        #1;
        model_ready = 1'b0;
        if (unit_start) begin
            model_cnt = unit_hang ? -1 : unit_latency;
            cap_a = unit_operand_a;
            cap_b = unit_operand_b;
        end else if (model_cnt > 0) begin
            model_cnt = model_cnt - 1;
            if (model_cnt == 0) begin
                model_ready = 1'b1;
                unit_result_val = use_fixed ? fixed_val : cap_a + cap_b;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int ref_pick(input logic [NR-1:0] r);
        for (int k = 0; k < NR; k++) begin
            if (r[(ref_ptr + k) % NR]) return (ref_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 64'(grant), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_result"}, 64'(result), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_terr"}, 64'(timeout_err), 0);
        check({tag, "_opa"}, 64'(unit_operand_a), 0);
        check({tag, "_opb"}, 64'(unit_operand_b), 0);
        check({tag, "_start"}, 64'(unit_start), 0);
        check({tag, "_state"}, 64'(state_dbg), 64'(IDLE));
    endtask

    // One full transaction from the IDLE cycle in which req is presented.
    task automatic run_txn(input int lat, input bit hang, output int w);
        int n;
        logic [DW-1:0] ea, eb, er;
        logic [NR-1:0] oh;
        w = ref_pick(req);
        if (w < 0) begin
            check("no_request", 64'(req), 64'hffff);
            return;
        end
        oh = NR'(1) << w;
        ea = op_a[w];
        eb = op_b[w];
        er = hang ? '0 : (use_fixed ? fixed_val : ea + eb);
        unit_latency = lat;
        unit_hang = hang;
        tick();
        check("issue_grant", 64'(grant), 64'(oh));
        check("issue_start", 64'(unit_start), 1);
        check("issue_busy", 64'(busy), 1);
        check("issue_opa", 64'(unit_operand_a), 64'(ea));
        check("issue_opb", 64'(unit_operand_b), 64'(eb));
        tick();
        check("wait_start_low", 64'(unit_start), 0);
        check("wait_state", 64'(state_dbg), 64'(WAIT));
        n = 0;
        while (done == '0 && n < 200) begin
            tick();
            n++;
        end
        if (hang) exp_terr = 1'b1;
        check("done_latency", 64'(n), 64'(hang ? TO : lat));
        check("done_onehot", 64'(done), 64'(oh));
        check("done_result", 64'(result), 64'(er));
        check("done_terr", 64'(timeout_err), 64'(exp_terr));
        check("done_opa_held", 64'(unit_operand_a), 64'(ea));
        req[w] = 1'b0;
        ref_ptr = (w + 1) % NR;
        tick();
        check("idle_done_low", 64'(done), 0);
        check("idle_busy_low", 64'(busy), 0);
        check("idle_grant_low", 64'(grant), 0);
        check("idle_result_held", 64'(result), 64'(er));
        check("idle_state", 64'(state_dbg), 64'(IDLE));
    endtask

    initial begin
        int w, last_w, n_txn, seen_done, lat;
        logic [NR-1:0] pending;

        for (int i = 0; i < NR; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        // Reset state
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Single request with latency 4
        op_a[0] = 32'h3F80_0000;
        op_b[0] = 32'h4000_0000;
        use_fixed = 1'b1;
        fixed_val = 32'h4040_0000;
        req = 3'b001;
        run_txn(4, 1'b0, w);
        check("single_winner", 64'(w), 0);
        use_fixed = 1'b0;

        // Spurious ready in IDLE
        force_ready = 1'b1;
        tick();
        force_ready = 1'b0;
        tick();
        check("spur_done", 64'(done), 0);
        check("spur_start", 64'(unit_start), 0);
        check("spur_busy", 64'(busy), 0);
        check("spur_state", 64'(state_dbg), 64'(IDLE));

        // Contention from reset: all three held
        reset = 1'b0;
        ref_ptr = 0;
        for (int i = 0; i < NR; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
        end
        req = 3'b111;
        tick();
        tick();
        reset = 1'b1;
        for (int t = 0; t < NR; t++) begin
            run_txn(2 + t, 1'b0, w);
            check("contention_order", 64'(w), 64'(t));
        end
        req = 3'b111;
        run_txn(3, 1'b0, w);
        check("contention_wrap", 64'(w), 0);
        req = 3'b000;
        while (ref_pick(3'b110 & {NR{1'b1}}) >= 0 && ref_ptr != 0) begin
            req = 3'b110;
            run_txn(1, 1'b0, w);
            req = 3'b000;
        end

        // Fairness: 0 and 2 re-request continuously, 1 joins later
        req = 3'b101;
        last_w = -1;
        for (int t = 0; t < 4; t++) begin
            run_txn($urandom_range(1, 6), 1'b0, w);
            if (last_w >= 0) check("fair_alternate", 64'(w == last_w), 0);
            last_w = w;
            req[w] = 1'b1;
        end
        req[1] = 1'b1;
        n_txn = 0;
        w = -1;
        while (w != 1 && n_txn < 6) begin
            run_txn($urandom_range(1, 6), 1'b0, w);
            n_txn++;
            if (w != 1) req[w] = 1'b1;
        end
        check("fair_req1_bound", 64'(n_txn <= 2), 1);
        req = '0;
        tick();

        // Randomized contention rounds
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NR; i++) begin
                op_a[i] = $urandom;
                op_b[i] = $urandom;
            end
            pending = NR'($urandom_range(1, 7));
            req = pending;
            while (req != '0) begin
                lat = $urandom_range(1, TO);
                run_txn(lat, 1'b0, w);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Hung unit, then a normal transaction with the sticky flag still set
        op_a[1] = $urandom;
        op_b[1] = $urandom;
        req = 3'b010;
        run_txn(1, 1'b1, w);
        op_a[2] = $urandom;
        op_b[2] = $urandom;
        req = 3'b100;
        run_txn(5, 1'b0, w);
        check("terr_sticky", 64'(timeout_err), 1);

        // Reset while in WAIT; the unit's late ready must be ignored
        req = 3'b010;
        unit_latency = 8;
        unit_hang = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("rst_pre_state", 64'(state_dbg), 64'(WAIT));
        reset = 1'b0;
        #1;
        exp_terr = 1'b0;
        ref_ptr = 0;
        check_all_zero("rst_async");
        req = '0;
        tick();
        tick();
        reset = 1'b1;
        seen_done = 0;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (done != '0 || unit_start || busy) seen_done++;
        end
        check("rst_no_done", 64'(seen_done), 0);
        check("rst_final_state", 64'(state_dbg), 64'(IDLE));
        check("rst_terr_cleared", 64'(timeout_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
